// File: rtl/systemizer_ctrl.sv
// Load/start/unload sequencer for the systemizer core: DEPTH-word load, bounded retries with timeout, then unload.
// Load accepts one beat per cycle in LOAD only; unload presents one word per 3 cycles and holds out_data until out_ready.
module systemizer_ctrl #(
  parameter int L         = 8,
  parameter int K         = 16,
  parameter int M         = 3,
  parameter int BLOCK     = 4,
  parameter int MAX_TRIES = 4,
  parameter int TIMEOUT   = 4096,
  localparam int DEPTH    = L * K / BLOCK,
  localparam int AW       = $clog2(DEPTH),
  localparam int DW       = BLOCK * $clog2(M),
  localparam int TW       = $clog2(MAX_TRIES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_start,
  input  logic [1:0]    cfg_left_op,
  input  logic [1:0]    cfg_right_op,
  output logic          busy,
  output logic          job_done,
  output logic          job_ok,
  output logic          err_timeout,
  output logic [TW-1:0] tries,
  output logic          retry_req,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          sys_rst,
  output logic          sys_start,
  output logic          sys_start_right,
  output logic [1:0]    sys_gen_left_op,
  output logic [1:0]    sys_gen_right_op,
  input  logic          sys_done,
  input  logic          sys_fail,
  input  logic          sys_success,
  output logic          sys_wr_en,
  output logic [AW-1:0] sys_wr_addr,
  output logic [DW-1:0] sys_data_in,
  output logic          sys_rd_en,
  output logic [AW-1:0] sys_rd_addr,
  input  logic [DW-1:0] sys_data_out
);

  localparam int TMW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW-1:0]  LAST  = AW'(DEPTH - 1);
  localparam logic [TMW-1:0] TLAST = TMW'(TIMEOUT - 1);
  localparam logic [TW-1:0]  MAXT  = TW'(MAX_TRIES);

  typedef enum logic [3:0] {IDLE, CLEAR, LOAD, RUN, WAIT, RD, CAPT, HOLD, FINISH} state_t;

  state_t         state, state_nxt;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [TMW-1:0] timer;
  logic           attempt_fail, timeout_hit;

  // Success is judged on sys_success alone; sys_fail carries no extra information.
  logic unused_sys_fail;
  assign unused_sys_fail = sys_fail;

  assign busy            = (state != IDLE);
  assign sys_start_right = 1'b0;

  always_comb begin
    state_nxt    = state;
    sys_rst      = !rst_n;
    sys_start    = 1'b0;
    in_ready     = 1'b0;
    sys_wr_en    = 1'b0;
    sys_wr_addr  = '0;
    sys_data_in  = '0;
    sys_rd_en    = 1'b0;
    sys_rd_addr  = '0;
    out_valid    = 1'b0;
    job_done     = 1'b0;
    retry_req    = 1'b0;
    attempt_fail = 1'b0;
    timeout_hit  = 1'b0;
    case (state)
      IDLE:  if (cmd_start) state_nxt = CLEAR;
      CLEAR: begin
        sys_rst   = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: begin
        in_ready    = 1'b1;
        sys_wr_addr = wr_ptr;
        if (in_valid) begin
          sys_wr_en   = 1'b1;
          sys_data_in = in_data;
          if (wr_ptr == LAST) state_nxt = RUN;
        end
      end
      RUN: begin
        sys_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        // A done response in the timeout cycle wins over the timeout.
        if (sys_done) begin
          if (sys_success) state_nxt = RD;
          else             attempt_fail = 1'b1;
        end else if (timer == TLAST) begin
          attempt_fail = 1'b1;
          timeout_hit  = 1'b1;
        end
        if (attempt_fail) begin
          if (tries == MAXT) begin
            state_nxt = FINISH;
          end else begin
            retry_req = 1'b1;
            state_nxt = CLEAR;
          end
        end
      end
      RD: begin
        sys_rd_en   = 1'b1;
        sys_rd_addr = rd_ptr;
        state_nxt   = CAPT;
      end
      CAPT: state_nxt = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = (rd_ptr == LAST) ? FINISH : RD;
      end
      FINISH: begin
        job_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      timer            <= '0;
      tries            <= '0;
      job_ok           <= 1'b0;
      err_timeout      <= 1'b0;
      out_data         <= '0;
      sys_gen_left_op  <= '0;
      sys_gen_right_op <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (cmd_start) begin
          sys_gen_left_op  <= cfg_left_op;
          sys_gen_right_op <= cfg_right_op;
          tries            <= '0;
          job_ok           <= 1'b0;
          err_timeout      <= 1'b0;
        end
        CLEAR: wr_ptr <= '0;
        LOAD:  if (in_valid && wr_ptr != LAST) wr_ptr <= wr_ptr + AW'(1);
        RUN: begin
          tries <= tries + TW'(1);
          timer <= '0;
        end
        WAIT: begin
          timer <= timer + TMW'(1);
          if (attempt_fail) err_timeout <= timeout_hit;
          if (sys_done && sys_success) rd_ptr <= '0;
        end
        CAPT: out_data <= sys_data_out;
        HOLD: if (out_ready) begin
          if (rd_ptr == LAST) job_ok <= 1'b1;
          else                rd_ptr <= rd_ptr + AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_systemizer_ctrl.sv
// Scoreboard bench for systemizer_ctrl: queued expectations for core writes, reads, unload data and job results.
// A second instance with TIMEOUT=16 and MAX_TRIES=1 covers the timeout path.
module tb_systemizer_ctrl;
  localparam int DEPTH = 32;

  typedef struct packed { logic ok; logic to; logic [2:0] tries; logic [1:0] l; logic [1:0] r; } job_exp_t;
  typedef struct packed { logic [4:0] addr; logic [7:0] dat; } wr_exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, cmd_start, in_valid, out_ready, sys_done, sys_fail, sys_success;
  logic [1:0] cfg_left_op, cfg_right_op;
  logic [7:0] in_data, sys_data_out;
  logic busy, job_done, job_ok, err_timeout, retry_req, in_ready, out_valid;
  logic sys_rst, sys_start, sys_start_right, sys_wr_en, sys_rd_en;
  logic [2:0] tries;
  logic [7:0] out_data, sys_data_in;
  logic [1:0] sys_gen_left_op, sys_gen_right_op;
  logic [4:0] sys_wr_addr, sys_rd_addr;

  systemizer_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cfg_left_op(cfg_left_op), .cfg_right_op(cfg_right_op),
    .busy(busy), .job_done(job_done), .job_ok(job_ok), .err_timeout(err_timeout), .tries(tries),
    .retry_req(retry_req), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .sys_rst(sys_rst),
    .sys_start(sys_start), .sys_start_right(sys_start_right), .sys_gen_left_op(sys_gen_left_op),
    .sys_gen_right_op(sys_gen_right_op), .sys_done(sys_done), .sys_fail(sys_fail), .sys_success(sys_success),
    .sys_wr_en(sys_wr_en), .sys_wr_addr(sys_wr_addr), .sys_data_in(sys_data_in), .sys_rd_en(sys_rd_en),
    .sys_rd_addr(sys_rd_addr), .sys_data_out(sys_data_out)
  );

  logic cmd_start2, in_valid2;
  logic busy2, job_done2, job_ok2, err_timeout2, retry_req2, in_ready2, out_valid2;
  logic sys_rst2, sys_start2, sys_start_right2, sys_wr_en2, sys_rd_en2;
  logic [0:0] tries2;
  logic [7:0] out_data2, sys_data_in2;
  logic [1:0] left2, right2;
  logic [4:0] wr_addr2, rd_addr2;

  systemizer_ctrl #(.TIMEOUT(16), .MAX_TRIES(1)) u_dut_to (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start2), .cfg_left_op(2'd3), .cfg_right_op(2'd1),
    .busy(busy2), .job_done(job_done2), .job_ok(job_ok2), .err_timeout(err_timeout2), .tries(tries2),
    .retry_req(retry_req2), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(8'h00),
    .out_valid(out_valid2), .out_ready(1'b0), .out_data(out_data2), .sys_rst(sys_rst2),
    .sys_start(sys_start2), .sys_start_right(sys_start_right2), .sys_gen_left_op(left2),
    .sys_gen_right_op(right2), .sys_done(1'b0), .sys_fail(1'b0), .sys_success(1'b0),
    .sys_wr_en(sys_wr_en2), .sys_wr_addr(wr_addr2), .sys_data_in(sys_data_in2), .sys_rd_en(sys_rd_en2),
    .sys_rd_addr(rd_addr2), .sys_data_out(8'h00)
  );

  wire [43:0] outs_main = {busy, job_done, job_ok, err_timeout, tries, retry_req, in_ready, out_valid, out_data,
                           sys_start, sys_start_right, sys_gen_left_op, sys_gen_right_op, sys_wr_en, sys_wr_addr,
                           sys_data_in, sys_rd_en, sys_rd_addr};
  wire [41:0] outs2 = {busy2, job_done2, job_ok2, err_timeout2, tries2, retry_req2, in_ready2, out_valid2, out_data2,
                       sys_start2, sys_start_right2, left2, right2, sys_wr_en2, wr_addr2, sys_data_in2, sys_rd_en2,
                       rd_addr2};

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: expected event missing or unexpected event seen", name);
  endtask

  // Scoreboard queues, filled by the stimulus side
  wr_exp_t  exp_wr[$];
  int       exp_rd[$];
  logic [7:0] exp_out[$];
  job_exp_t exp_job[$];
  int       core_modes[$];   // 0 success, 1 fail, 2 silent

  // Core model: memory plus scripted status response in the 10th WAIT cycle
  logic [7:0] mem [DEPTH];
  always @(posedge clk) begin
    if (sys_wr_en) mem[sys_wr_addr] <= sys_data_in;
    if (sys_rd_en) sys_data_out <= ~mem[sys_rd_addr];
  end

  int done_cyc = -1;
  initial begin
    int mode;
    forever begin
      @(negedge clk iff (sys_start === 1'b1));
      mode = (core_modes.size() != 0) ? core_modes.pop_front() : 0;
      if (mode != 2) begin
        repeat (10) @(posedge clk);
        #1;
        sys_done = 1'b1; sys_success = (mode == 0); sys_fail = (mode == 1); done_cyc = cyc;
        @(posedge clk);
        #1;
        sys_done = 1'b0; sys_success = 1'b0; sys_fail = 1'b0;
      end
    end
  end

  // Feeder: presents words base+idx, idx wraps so each retry resupplies the same matrix
  bit feed_en = 1'b0, feed_gaps = 1'b0;
  int feed_idx = 0;
  logic [7:0] feed_base = 8'h00;
  initial forever begin
    @(posedge clk);
    #1;
    if (feed_en) begin
      in_valid = feed_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = feed_base + 8'(feed_idx);
    end else begin
      in_valid = 1'b0;
    end
    @(negedge clk);
    if (in_valid && in_ready) feed_idx = (feed_idx == DEPTH - 1) ? 0 : feed_idx + 1;
  end

  int sink_mode = 0;   // 0 always ready, 1 random stalls, 2 never ready
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = (sink_mode == 0) ? 1'b1 : (sink_mode == 1) ? ($urandom_range(0, 2) == 0) : 1'b0;
  end

  // Monitor
  int retry_cnt, rst_cnt, rd_cnt, done_cnt = 0;
  int start_cyc, first_rd, first_ov, last_hs, job_done_cyc, retry_cyc;
  bit retry_pend, stall_prev;
  logic [7:0] stall_dat;
  wr_exp_t w_e;
  job_exp_t j_e;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      stall_prev = 1'b0;
      retry_pend = 1'b0;
    end else begin
      if (sys_wr_en) begin
        if (exp_wr.size() == 0) fail_now("wr_extra");
        else begin
          w_e = exp_wr.pop_front();
          check("wr_addr", sys_wr_addr, w_e.addr);
          check("wr_data", sys_data_in, w_e.dat);
        end
      end
      if (sys_rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
        if (exp_rd.size() == 0) fail_now("rd_extra");
        else check("rd_addr", sys_rd_addr, exp_rd.pop_front());
      end
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (stall_prev && out_valid) check("out_stable", out_data, stall_dat);
      stall_prev = out_valid && !out_ready;
      stall_dat  = out_data;
      if (out_valid && out_ready) begin
        last_hs = cyc;
        if (exp_out.size() == 0) fail_now("out_extra");
        else check("out_data", out_data, exp_out.pop_front());
      end
      if (retry_req) begin
        retry_cnt++;
        check("retry_in_fail_cycle", cyc, done_cyc);
        retry_cyc  = cyc;
        retry_pend = 1'b1;
      end
      if (sys_rst) begin
        rst_cnt++;
        if (retry_pend) check("clear_after_retry", cyc - retry_cyc, 1);
        retry_pend = 1'b0;
      end
      if (sys_start) start_cyc = cyc;
      if (job_done) begin
        done_cnt++;
        job_done_cyc = cyc;
        if (exp_job.size() == 0) fail_now("job_done_extra");
        else begin
          j_e = exp_job.pop_front();
          check("job_ok", job_ok, j_e.ok);
          check("err_timeout", err_timeout, j_e.to);
          check("tries", tries, j_e.tries);
          check("left_op", sys_gen_left_op, j_e.l);
          check("right_op", sys_gen_right_op, j_e.r);
        end
      end
    end
  end

  int job_cyc;
  task automatic start_job(input logic [1:0] l, input logic [1:0] r, input logic [7:0] base,
                           input int attempts, input bit succeed, input logic [2:0] exp_tries);
    job_exp_t j;
    for (int a = 0; a < attempts; a++)
      for (int i = 0; i < DEPTH; i++) exp_wr.push_back({5'(i), base + 8'(i)});
    if (succeed)
      for (int i = 0; i < DEPTH; i++) begin
        exp_rd.push_back(i);
        exp_out.push_back(~(base + 8'(i)));
      end
    j.ok = succeed; j.to = 1'b0; j.tries = exp_tries; j.l = l; j.r = r;
    exp_job.push_back(j);
    retry_cnt = 0; rst_cnt = 0; rd_cnt = 0; first_rd = -1; first_ov = -1;
    feed_base = base; feed_idx = 0; feed_en = 1'b1;
    cfg_left_op = l; cfg_right_op = r; cmd_start = 1'b1; job_cyc = cyc;
    @(posedge clk);
    #1;
    cmd_start = 1'b0; cfg_left_op = ~l; cfg_right_op = ~r;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (done_cnt == d0) fail_now({tag, "_job_done_timeout"});
    feed_en = 1'b0;
    check({tag, "_wr_q_empty"}, exp_wr.size(), 0);
    check({tag, "_out_q_empty"}, exp_out.size(), 0);
  endtask

  task automatic reset_mid(input string tag);
    int d0;
    rst_n = 1'b0; feed_en = 1'b0;
    @(negedge clk);
    check({tag, "_sys_rst_during_reset"}, sys_rst, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check({tag, "_outputs_zero"}, outs_main, 0);
    check({tag, "_sys_rst_held"}, sys_rst, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1; sink_mode = 0; feed_idx = 0;
    exp_wr.delete(); exp_rd.delete(); exp_out.delete(); exp_job.delete(); core_modes.delete();
    d0 = done_cnt;
    repeat (20) @(posedge clk);
    #1;
    check({tag, "_no_job_done"}, done_cnt - d0, 0);
    check({tag, "_idle_after"}, busy, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s2, d2, r2;
    rst_n = 1'b0; cmd_start = 1'b0; cfg_left_op = 2'd0; cfg_right_op = 2'd0;
    sys_done = 1'b0; sys_fail = 1'b0; sys_success = 1'b0;
    cmd_start2 = 1'b0; in_valid2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outputs_zero", outs_main, 0);
    check("reset_sys_rst", sys_rst, 1);
    check("reset_outputs_zero_to", outs2, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Timeout instance: silent core, one try
    cmd_start2 = 1'b1; in_valid2 = 1'b1;
    @(posedge clk);
    #1;
    cmd_start2 = 1'b0;
    s2 = -1; d2 = -1; n = 0; r2 = 0;
    while (d2 < 0 && n < 300) begin
      @(negedge clk);
      n++;
      if (sys_start2) s2 = cyc;
      if (retry_req2) r2++;
      if (job_done2) begin
        d2 = cyc;
        check("to_err_timeout", err_timeout2, 1);
        check("to_job_ok", job_ok2, 0);
        check("to_tries", tries2, 1);
      end
      @(posedge clk);
      #1;
    end
    in_valid2 = 1'b0;
    if (d2 < 0) fail_now("to_job_done_missing");
    else check("to_latency", d2 - s2, 17);
    check("to_no_retry", r2, 0);

    // Job 1: straight-through success
    core_modes.push_back(0);
    start_job(2'd1, 2'd2, 8'h00, 1, 1'b1, 3'd1);
    wait_done("job1", 1000);
    check("job1_start_cycle", start_cyc - job_cyc, 34);
    check("job1_rd_count", rd_cnt, 32);
    check("job1_first_rd", first_rd - done_cyc, 1);
    check("job1_first_out_valid", first_ov - done_cyc, 3);
    check("job1_unload_rate", last_hs - first_ov, 93);
    check("job1_done_after_hs", job_done_cyc - last_hs, 1);
    check("job1_retries", retry_cnt, 0);

    // Job 2: fail, fail, success
    core_modes.push_back(1); core_modes.push_back(1); core_modes.push_back(0);
    start_job(2'd3, 2'd0, 8'h40, 3, 1'b1, 3'd3);
    wait_done("job2", 2000);
    check("job2_retries", retry_cnt, 2);
    check("job2_sys_rst_pulses", rst_cnt, 3);

    // Job 3: every attempt fails
    for (int i = 0; i < 4; i++) core_modes.push_back(1);
    start_job(2'd2, 2'd1, 8'h80, 4, 1'b0, 3'd4);
    wait_done("job3", 2000);
    check("job3_retries", retry_cnt, 3);
    check("job3_no_reads", rd_cnt, 0);

    // Job 4: input gaps, output stalls, ignored cmd_start while busy
    core_modes.push_back(0);
    feed_gaps = 1'b1; sink_mode = 1;
    start_job(2'd1, 2'd3, 8'hC0, 1, 1'b1, 3'd1);
    for (int k = 0; k < 4; k++) begin
      cmd_start = 1'b1; cfg_left_op = 2'(k); cfg_right_op = 2'(k);
      @(posedge clk);
      #1;
      cmd_start = 1'b0;
      @(posedge clk);
      #1;
    end
    wait_done("job4", 3000);
    feed_gaps = 1'b0; sink_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check("job4_idle_after", busy, 0);

    // Reset mid-LOAD
    start_job(2'd2, 2'd2, 8'h10, 1, 1'b1, 3'd1);
    repeat (10) @(posedge clk);
    #1;
    reset_mid("rst_load");

    // Reset mid-HOLD
    core_modes.push_back(0);
    sink_mode = 2;
    start_job(2'd3, 2'd3, 8'h20, 1, 1'b1, 3'd1);
    n = 0;
    while (!out_valid && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) fail_now("hold_not_reached");
    repeat (3) @(posedge clk);
    #1;
    reset_mid("rst_hold");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
